// File: rtl/rv32i_pkg.sv
// Shared RV32I register-file constants and the write-back entry record.
// The regfile, the hazard logic and the write-back queue all use these.
package rv32i_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    // One pending register write: destination and value.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wb_queue_if.sv
// Bundle of producer handshakes, regfile write port, forwarding ports and
// queue status. The queue is the slave; producers/regfile/decode are the master.
interface regfile_wb_queue_if #(
    parameter int DEPTH = 4
);
    import rv32i_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    // execute producer
    logic              ex_valid;
    logic              ex_ready;
    logic [ADDR_W-1:0] ex_addr;
    logic [DATA_W-1:0] ex_data;

    // load producer
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;

    // regfile write port
    logic              port_busy;
    logic [ADDR_W-1:0] w_addr_reg;
    logic [DATA_W-1:0] w_data_reg;
    logic              w_ctrl_reg;

    // decode forwarding
    logic [ADDR_W-1:0] fwd_addr1;
    logic [ADDR_W-1:0] fwd_addr2;
    logic              fwd_hit1;
    logic              fwd_hit2;
    logic [DATA_W-1:0] fwd_data1;
    logic [DATA_W-1:0] fwd_data2;

    // status
    logic [CNT_W-1:0]  pending_cnt;
    logic              empty;
    logic              full;

    modport slave (
        input  ex_valid, ex_addr, ex_data,
        input  ld_valid, ld_addr, ld_data,
        input  port_busy, fwd_addr1, fwd_addr2,
        output ex_ready, ld_ready,
        output w_addr_reg, w_data_reg, w_ctrl_reg,
        output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
        output pending_cnt, empty, full
    );

    modport master (
        output ex_valid, ex_addr, ex_data,
        output ld_valid, ld_addr, ld_data,
        output port_busy, fwd_addr1, fwd_addr2,
        input  ex_ready, ld_ready,
        input  w_addr_reg, w_data_reg, w_ctrl_reg,
        input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
        input  pending_cnt, empty, full
    );

endinterface

// File: rtl/wb_fwd_match.sv
// Youngest-match search over the pending write-back entries for one read port.
// Entries arrive ordered oldest (index 0) to youngest (index DEPTH-1).
module wb_fwd_match
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wb_entry_t         entries [DEPTH],
    input  logic [DEPTH-1:0]  valid,
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [DATA_W-1:0] data
);

    // Later (younger) matches override earlier ones; x0 never forwards.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (addr != '0) && (entries[i].addr == addr)) begin
                hit  = 1'b1;
                data = entries[i].data;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// Write-back queue in front of the regfile write port. Accepts one result per
// cycle (load has priority over execute), drains one per cycle when the port is
// free, and forwards pending values to the two decode read ports.
module regfile_wb_queue
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic              clk,
    input logic              rst,
    regfile_wb_queue_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t          mem_reg [DEPTH];
    logic [PTR_W-1:0]   head_reg;
    logic [PTR_W-1:0]   tail_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_next;

    logic               full;
    logic               empty;
    logic               ld_fire;
    logic               ex_fire;
    logic               push_en;
    logic               pop_en;
    wb_entry_t          push_entry;

    wb_entry_t          age_entries [DEPTH];
    logic [DEPTH-1:0]   age_valid;

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);

    // Readiness depends only on the current fill level, never on a same-cycle pop.
    assign bus.ld_ready = !full;
    assign bus.ex_ready = !full && !bus.ld_valid;

    assign ld_fire = bus.ld_valid && !full;
    assign ex_fire = bus.ex_valid && !full && !bus.ld_valid;

    // Select the accepted producer; the load wins whenever it is offering.
    always_comb begin
        push_entry.addr = bus.ex_addr;
        push_entry.data = bus.ex_data;
        if (bus.ld_valid) begin
            push_entry.addr = bus.ld_addr;
            push_entry.data = bus.ld_data;
        end
    end

    // Writes to x0 complete the handshake but are never stored.
    assign push_en = (ld_fire || ex_fire) && (push_entry.addr != '0);
    assign pop_en  = !empty && !bus.port_busy;

    // Occupancy: a push and pop in the same cycle cancel out.
    always_comb begin
        count_next = count_reg;
        case ({push_en, pop_en})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // Pointer and count state; reset drops everything in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push_en) tail_reg <= tail_reg + PTR_W'(1);
            if (pop_en)  head_reg <= head_reg + PTR_W'(1);
            count_reg <= count_next;
        end
    end

    // Entry storage, written at the tail slot on each stored push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
        end else if (push_en) begin
            mem_reg[tail_reg] <= push_entry;
        end
    end

    // Age-ordered view of the ring: slot gi is the gi-th oldest pending entry.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_age
            assign age_entries[gi] = mem_reg[head_reg + PTR_W'(gi)];
            assign age_valid[gi]   = (CNT_W'(gi) < count_reg);
        end
    endgenerate

    // Regfile write port: head entry when draining, all zero otherwise.
    always_comb begin
        bus.w_ctrl_reg = 1'b0;
        bus.w_addr_reg = '0;
        bus.w_data_reg = '0;
        if (pop_en) begin
            bus.w_ctrl_reg = 1'b1;
            bus.w_addr_reg = mem_reg[head_reg].addr;
            bus.w_data_reg = mem_reg[head_reg].data;
        end
    end

    assign bus.pending_cnt = count_reg;
    assign bus.empty       = empty;
    assign bus.full        = full;

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
        .entries (age_entries),
        .valid   (age_valid),
        .addr    (bus.fwd_addr1),
        .hit     (bus.fwd_hit1),
        .data    (bus.fwd_data1)
    );

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
        .entries (age_entries),
        .valid   (age_valid),
        .addr    (bus.fwd_addr2),
        .hit     (bus.fwd_hit2),
        .data    (bus.fwd_data2)
    );

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Scoreboard bench for regfile_wb_queue: stimulus pushes expected regfile
// writes into a queue, a negedge monitor checks status, readiness, forwarding
// and every drained write against that queue.
module tb_regfile_wb_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int total = 0;
    int bad   = 0;

    exp_t exp_q[$];
    int   occ    = 0;
    bit   mon_en = 1'b0;

    regfile_wb_queue_if #(.DEPTH(DEPTH)) bus ();

    regfile_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs, predict acceptance from the model occupancy,
    // and record stored writes at the edge that accepts them.
    task automatic step(input logic lv, input logic [4:0] la, input logic [31:0] ldd,
                        input logic ev, input logic [4:0] ea, input logic [31:0] edd,
                        input logic busy, input logic [4:0] f1, input logic [4:0] f2,
                        output logic l_acc, output logic e_acc);
        bit drn;
        bus.ld_valid  = lv;
        bus.ld_addr   = la;
        bus.ld_data   = ldd;
        bus.ex_valid  = ev;
        bus.ex_addr   = ea;
        bus.ex_data   = edd;
        bus.port_busy = busy;
        bus.fwd_addr1 = f1;
        bus.fwd_addr2 = f2;
        l_acc = lv && (occ < DEPTH);
        e_acc = ev && (occ < DEPTH) && !lv;
        drn   = (occ > 0) && !busy;
        @(posedge clk);
        if (l_acc) begin
            $display("accept ld x%0d = %08h", la, ldd);
            if (la != 0) begin exp_q.push_back('{la, ldd}); occ++; end
        end else if (e_acc) begin
            $display("accept ex x%0d = %08h", ea, edd);
            if (ea != 0) begin exp_q.push_back('{ea, edd}); occ++; end
        end
        if (drn) occ--;
        #1;
    endtask

    task automatic idle(input logic busy);
        logic a, b;
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, busy, 5'd0, 5'd0, a, b);
    endtask

    // Assert reset asynchronously, check reset outputs at once, release later.
    task automatic do_reset();
        mon_en = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_w_ctrl", bus.w_ctrl_reg, 0);
        chk("rst_w_addr", bus.w_addr_reg, 0);
        chk("rst_w_data", bus.w_data_reg, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_pending", bus.pending_cnt, 0);
        chk("rst_fwd_hit1", bus.fwd_hit1, 0);
        chk("rst_fwd_data1", bus.fwd_data1, 0);
        chk("rst_fwd_hit2", bus.fwd_hit2, 0);
        chk("rst_ld_ready", bus.ld_ready, 1);
        chk("rst_ex_ready", bus.ex_ready, !bus.ld_valid);
        exp_q.delete();
        occ = 0;
        bus.ld_valid = 1'b0;
        bus.ex_valid = 1'b0;
        bus.port_busy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
    endtask

    // Monitor: compare everything the DUT presents against the expected queue.
    initial begin
        int   sz;
        bit   h1, h2, drain;
        logic [31:0] d1, d2;
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                sz = exp_q.size();
                chk("pending_cnt", bus.pending_cnt, sz);
                chk("empty", bus.empty, sz == 0);
                chk("full", bus.full, sz == DEPTH);
                chk("ld_ready", bus.ld_ready, sz < DEPTH);
                chk("ex_ready", bus.ex_ready, (sz < DEPTH) && !bus.ld_valid);
                h1 = 0; d1 = 0; h2 = 0; d2 = 0;
                foreach (exp_q[k]) begin
                    if (bus.fwd_addr1 != 0 && exp_q[k].addr == bus.fwd_addr1) begin h1 = 1; d1 = exp_q[k].data; end
                    if (bus.fwd_addr2 != 0 && exp_q[k].addr == bus.fwd_addr2) begin h2 = 1; d2 = exp_q[k].data; end
                end
                chk("fwd_hit1", bus.fwd_hit1, h1);
                chk("fwd_data1", bus.fwd_data1, d1);
                chk("fwd_hit2", bus.fwd_hit2, h2);
                chk("fwd_data2", bus.fwd_data2, d2);
                drain = (sz > 0) && !bus.port_busy;
                chk("w_ctrl", bus.w_ctrl_reg, drain);
                if (drain) begin
                    e = exp_q.pop_front();
                    chk("w_addr", bus.w_addr_reg, e.addr);
                    chk("w_data", bus.w_data_reg, e.data);
                    $display("write x%0d = %08h", bus.w_addr_reg, bus.w_data_reg);
                end else begin
                    chk("w_addr_idle", bus.w_addr_reg, 0);
                    chk("w_data_idle", bus.w_data_reg, 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic la, ea;
        int   n;
        bit   p_lv, p_ev;
        logic [4:0]  p_la, p_ea;
        logic [31:0] p_ld, p_ed;

        bus.ld_valid = 0; bus.ld_addr = 0; bus.ld_data = 0;
        bus.ex_valid = 0; bus.ex_addr = 0; bus.ex_data = 0;
        bus.port_busy = 0; bus.fwd_addr1 = 0; bus.fwd_addr2 = 0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // single execute write
        step(0, 0, 0, 1, 5'd5, 32'h1234, 0, 5'd5, 0, la, ea);
        idle(0);
        idle(0);

        // load and execute together: load first, execute next cycle
        step(1, 5'd3, 32'hAA, 1, 5'd4, 32'hBB, 0, 5'd3, 5'd4, la, ea);
        step(0, 0, 0, 1, 5'd4, 32'hBB, 0, 5'd3, 5'd4, la, ea);
        repeat (3) idle(0);

        // fill while the port is busy, fifth stalls, then release
        for (int i = 1; i <= 4; i++)
            step(1, 5'(i), 32'h100 + i, 0, 0, 0, 1, 5'd2, 5'd4, la, ea);
        step(1, 5'd5, 32'h105, 0, 0, 0, 1, 5'd5, 5'd1, la, ea);
        n = 0;
        do begin
            step(1, 5'd5, 32'h105, 0, 0, 0, 0, 5'd5, 5'd1, la, ea);
            n++;
        end while (!la && n < 8);
        if (!la) chk("x5_accept_timeout", 0, 1);
        repeat (6) idle(0);

        // two pending writes to x7, forward the younger
        step(0, 0, 0, 1, 5'd7, 32'h11, 1, 5'd7, 5'd0, la, ea);
        step(0, 0, 0, 1, 5'd7, 32'h22, 1, 5'd7, 5'd0, la, ea);
        step(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd0, la, ea);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 5'd7, 5'd0, la, ea);

        // x0 write is accepted but discarded
        step(0, 0, 0, 1, 5'd0, 32'hDEAD, 0, 5'd0, 5'd0, la, ea);
        repeat (2) idle(0);

        // reset with three entries pending
        step(1, 5'd9, 32'h9, 0, 0, 0, 1, 0, 0, la, ea);
        step(1, 5'd10, 32'hA, 0, 0, 0, 1, 0, 0, la, ea);
        step(1, 5'd11, 32'hB, 0, 0, 0, 1, 0, 0, la, ea);
        bus.ld_valid = 1; bus.port_busy = 0; bus.fwd_addr1 = 5'd9; bus.fwd_addr2 = 5'd11;
        do_reset();
        repeat (3) idle(0);

        // randomized traffic with producers holding offers until accepted
        p_lv = 0; p_ev = 0; p_la = 0; p_ea = 0; p_ld = 0; p_ed = 0;
        for (int c = 0; c < 300; c++) begin
            if (!p_lv && $urandom_range(0, 99) < 35) begin
                p_lv = 1; p_la = 5'($urandom_range(0, 7)); p_ld = $urandom;
            end
            if (!p_ev && $urandom_range(0, 99) < 50) begin
                p_ev = 1; p_ea = 5'($urandom_range(0, 7)); p_ed = $urandom;
            end
            step(p_lv, p_la, p_ld, p_ev, p_ea, p_ed, $urandom_range(0, 99) < 30,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), la, ea);
            if (la) p_lv = 0;
            if (ea) p_ev = 0;
        end

        // drain remaining entries within a bounded number of cycles
        n = 0;
        while (occ > 0 && n < 20) begin
            idle(0);
            n++;
        end
        if (occ > 0) chk("final_drain_timeout", occ, 0);
        repeat (2) idle(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_queue.md
# regfile_wb_queue

Write-back queue sitting in front of the `regfile` write port. It accepts results from two producers: the single-cycle execute path and the variable-latency load unit. It buffers them in program-arrival order and drains one entry per cycle onto `w_addr_reg`/`w_data_reg`/`w_ctrl_reg`. It also forwards pending, not-yet-written values to the two decode read ports so readers never see stale register contents.

## Interface
- `DEPTH`, 4: queue entries; power of two, at least 2.
- `ADDR_W`, 5: register address width.
- `DATA_W`, 32: register data width.

- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `ex_valid`  in  1  execute result offered.
- `ex_ready`  out  1  execute result accepted this cycle.
- `ex_addr`  in  ADDR_W  execute destination register.
- `ex_data`  in  DATA_W  execute result.
- `ld_valid`  in  1  load result offered.
- `ld_ready`  out  1  load result accepted this cycle.
- `ld_addr`  in  ADDR_W  load destination register.
- `ld_data`  in  DATA_W  load result.
- `port_busy`  in  1  regfile write port unavailable this cycle; suppresses drain.
- `w_addr_reg`  out  ADDR_W  regfile write address.
- `w_data_reg`  out  DATA_W  regfile write data.
- `w_ctrl_reg`  out  1  regfile write enable.
- `fwd_addr1`, `fwd_addr2`  in  ADDR_W  decode read addresses.
- `fwd_hit1`, `fwd_hit2`  out  1  a pending entry matches.
- `fwd_data1`, `fwd_data2`  out  DATA_W  youngest matching pending data.
- `pending_cnt`  out  $clog2(DEPTH)+1  occupied entries.
- `empty`, `full`  out  1  queue status.

## Operation
- Circular buffer: head pointer, tail pointer, count.
- One enqueue per cycle at most.
  - `ld_ready` = !full.
  - `ex_ready` = !full && !ld_valid. The load has priority.
- Handshake: a transfer occurs when valid && ready. Producers hold addr/data stable while valid && !ready.
- Writes to x0: `ready` follows the rules above, but the transfer is discarded. Nothing is enqueued and the count is unchanged.
- Drain, when !empty && !port_busy:
  - `w_ctrl_reg`=1, with `w_addr_reg`/`w_data_reg` taken from the head entry.
  - The head pops at the same edge the regfile captures the write.
- Outputs when empty or `port_busy`: `w_ctrl_reg`=0, `w_addr_reg`=0, `w_data_reg`=0.
- Simultaneous push and pop: the count is unchanged and both pointers advance.
  - `ready` depends only on `full`; a pop in the same cycle does not free a slot for the push.
- Forwarding:
  - Combinational search over the occupied entries.
  - `fwd_hitN`=1 if any entry's addr equals `fwd_addrN` and `fwd_addrN`≠0.
  - `fwd_dataN` is the data of the youngest such entry, else 0.
  - The head entry being drained this cycle still counts as pending.
- Pointer wrap: modulo DEPTH. `full` is count==DEPTH; `empty` is count==0.

## Timing
- Reset (asynchronous assert, synchronous-safe release):
  - Pointers and count go to 0, all entries are invalidated, and in-flight entries are dropped.
  - Output reset values: `empty`=1, `full`=0, `pending_cnt`=0, `w_*`=0, `fwd_hit*`=0, `fwd_data*`=0, `ld_ready`=1, `ex_ready`=!ld_valid.
- Latency:
  - A result accepted at edge N appears on the `w_*` outputs in cycle N+1 if the queue was empty, and the regfile is written at edge N+1.
  - Otherwise it is written after all older entries drain.
- Forwarding reflects an accepted entry from cycle N+1 until its drain edge. From that edge on, the regfile holds the value.
- Throughput: one write per cycle sustained while `port_busy`=0.

## Structure
- Shared package `rv32i_pkg`: `ADDR_W`/`DATA_W` constants and the `wb_entry_t` struct {addr, data}. The regfile and the hazard logic use the same constants.
- Sub-module `wb_fwd_match`: youngest-match priority search over DEPTH entries, instantiated twice (one per read port).
- Storage, pointers, and arbitration stay in `regfile_wb_queue`.

## Test plan
- Reset, then ex push (x5, 0x1234) → `w_ctrl_reg`=1, `w_addr_reg`=5, `w_data_reg`=0x1234 the next cycle; `empty`=1 after that edge.
- `ld_valid` and `ex_valid` asserted together (ld: x3=0xAA, ex: x4=0xBB) → load accepted first with `ex_ready`=0; ex accepted the next cycle; drains x3 then x4.
- `port_busy`=1 with 5 pushes to x1..x5 → `full`=1 after 4 and the 5th stalls (`ld_ready`=0); release `port_busy` → x1..x4 drain in order over 4 cycles, then x5.
- Two pending writes to x7 (0x11 then 0x22), `fwd_addr1`=7 → `fwd_hit1`=1, `fwd_data1`=0x22; `fwd_addr2`=0 → `fwd_hit2`=0.
- Push to x0 with data 0xDEAD → handshake completes, `pending_cnt` stays 0, `w_ctrl_reg` never asserts.
- Assert `rst` low with 3 entries pending → all outputs return to their reset values immediately; no regfile write occurs after release.
